// File: rtl/calc_pkg.sv
// Shared key codes and entry FSM states for the calculator front end.
package calc_pkg;

  localparam int unsigned KEY_W = 5;

  localparam logic [KEY_W-1:0] KEY_CLEAR = 5'h10;
  localparam logic [KEY_W-1:0] KEY_BKSP  = 5'h11;
  localparam logic [KEY_W-1:0] KEY_NEG   = 5'h12;
  localparam logic [KEY_W-1:0] KEY_ENTER = 5'h13;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    DISP = 2'd2,
    SEND = 2'd3
  } entry_state_t;

endpackage

// File: rtl/operand_entry.sv
// Builds a sign+magnitude hex operand from keypad codes, pushes each new value
// to the display port and hands the finished operand out on ENTER.
module operand_entry
  import calc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_DIGITS = DATA_WIDTH / 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_W-1:0]      i_key,
  input  logic                  i_key_valid,
  output logic                  o_key_ready,
  output logic [DATA_WIDTH-1:0] o_disp_data,
  output logic                  o_disp_2s_comp,
  output logic                  o_disp_valid,
  input  logic                  i_disp_ready,
  output logic [DATA_WIDTH-1:0] o_op_data,
  output logic                  o_op_valid,
  input  logic                  i_op_ready
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  entry_state_t          r_state, w_state_n;
  logic [DATA_WIDTH-1:0] r_mag, w_mag_n;
  logic                  r_neg, w_neg_n;
  logic [CNT_W-1:0]      r_cnt, w_cnt_n;
  logic [DATA_WIDTH-1:0] r_disp_data, w_disp_data_n;
  logic                  r_disp_neg, w_disp_neg_n;
  logic [DATA_WIDTH-1:0] r_op_data, w_op_data_n;
  logic                  w_load_disp;

  function automatic logic [DATA_WIDTH-1:0] to_value(input logic [DATA_WIDTH-1:0] mag,
                                                     input logic                  neg);
    return neg ? (~mag + DATA_WIDTH'(1)) : mag;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_mag       <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_disp_data <= '0;
      r_disp_neg  <= 1'b0;
      r_op_data   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_mag       <= w_mag_n;
      r_neg       <= w_neg_n;
      r_cnt       <= w_cnt_n;
      r_disp_data <= w_disp_data_n;
      r_disp_neg  <= w_disp_neg_n;
      r_op_data   <= w_op_data_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_mag_n       = r_mag;
    w_neg_n       = r_neg;
    w_cnt_n       = r_cnt;
    w_op_data_n   = r_op_data;
    w_load_disp   = 1'b0;
    w_disp_data_n = r_disp_data;
    w_disp_neg_n  = r_disp_neg;

    case (r_state)
      INIT: begin
        w_state_n   = DISP;
        w_load_disp = 1'b1;
      end
      IDLE: begin
        if (i_key_valid) begin
          if (i_key < KEY_CLEAR) begin
            // Leading zeros and digits beyond capacity are swallowed silently.
            if ((r_cnt < MAX_CNT) && !((i_key[3:0] == 4'h0) && (r_cnt == '0))) begin
              w_mag_n     = (r_mag << 4) | DATA_WIDTH'(i_key[3:0]);
              w_cnt_n     = r_cnt + CNT_W'(1);
              w_state_n   = DISP;
              w_load_disp = 1'b1;
            end
          end else begin
            case (i_key)
              KEY_CLEAR: begin
                w_mag_n     = '0;
                w_neg_n     = 1'b0;
                w_cnt_n     = '0;
                w_state_n   = DISP;
                w_load_disp = 1'b1;
              end
              KEY_BKSP: begin
                if (r_cnt != '0) begin
                  w_mag_n     = r_mag >> 4;
                  w_cnt_n     = r_cnt - CNT_W'(1);
                  w_neg_n     = (r_cnt == CNT_W'(1)) ? 1'b0 : r_neg;
                  w_state_n   = DISP;
                  w_load_disp = 1'b1;
                end
              end
              KEY_NEG: begin
                if (r_mag != '0) begin
                  w_neg_n     = ~r_neg;
                  w_state_n   = DISP;
                  w_load_disp = 1'b1;
                end
              end
              KEY_ENTER: begin
                w_op_data_n = to_value(r_mag, r_neg);
                w_state_n   = SEND;
              end
              default: ;
            endcase
          end
        end
      end
      DISP: begin
        if (i_disp_ready) w_state_n = IDLE;
      end
      SEND: begin
        if (i_op_ready) begin
          w_mag_n     = '0;
          w_neg_n     = 1'b0;
          w_cnt_n     = '0;
          w_state_n   = DISP;
          w_load_disp = 1'b1;
        end
      end
      default: w_state_n = INIT;
    endcase

    // Display registers only reload on entry to DISP so they hold through backpressure.
    if (w_load_disp) begin
      w_disp_data_n = to_value(w_mag_n, w_neg_n);
      w_disp_neg_n  = w_neg_n;
    end
  end

  assign o_key_ready    = (r_state == IDLE);
  assign o_disp_valid   = (r_state == DISP);
  assign o_op_valid     = (r_state == SEND);
  assign o_disp_data    = r_disp_data;
  assign o_disp_2s_comp = r_disp_neg;
  assign o_op_data      = r_op_data;

endmodule

// File: tb/tb_operand_entry.sv
// Directed vector bench for operand_entry: key table plus backpressure and reset sequences.
module tb_operand_entry;

  localparam int K_NONE = 0;
  localparam int K_DISP = 1;
  localparam int K_OP   = 2;

  typedef struct {
    logic [4:0]  key;
    int          kind;
    logic [15:0] data;
    logic        neg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  i_key = '0;
  logic        i_key_valid = 1'b0;
  logic        o_key_ready;
  logic [15:0] o_disp_data;
  logic        o_disp_2s_comp;
  logic        o_disp_valid;
  logic        i_disp_ready = 1'b1;
  logic [15:0] o_op_data;
  logic        o_op_valid;
  logic        i_op_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  operand_entry #(.DATA_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_key         (i_key),
    .i_key_valid   (i_key_valid),
    .o_key_ready   (o_key_ready),
    .o_disp_data   (o_disp_data),
    .o_disp_2s_comp(o_disp_2s_comp),
    .o_disp_valid  (o_disp_valid),
    .i_disp_ready  (i_disp_ready),
    .o_op_data     (o_op_data),
    .o_op_valid    (o_op_valid),
    .i_op_ready    (i_op_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int unsigned n = 0;
    @(negedge clk);
    while (!o_key_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!o_key_ready) chk({name, "_ready_timeout"}, 32'(o_key_ready), 32'd1);
  endtask

  // Drive one key once the block is ready; leaves the DUT one cycle after acceptance.
  task automatic press(input logic [4:0] k);
    wait_ready("press");
    i_key       = k;
    i_key_valid = 1'b1;
    @(posedge clk);
    #1;
    i_key_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [4:0] k, input int kind,
                              input logic [15:0] d, input logic n);
    vec_t v;
    v.key = k; v.kind = kind; v.data = d; v.neg = n;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(5'h01, K_DISP, 16'h0001, 1'b0));
    tbl.push_back(mk(5'h02, K_DISP, 16'h0012, 1'b0));
    tbl.push_back(mk(5'h0A, K_DISP, 16'h012A, 1'b0));
    tbl.push_back(mk(5'h0F, K_DISP, 16'h12AF, 1'b0));
    tbl.push_back(mk(5'h07, K_NONE, 16'h0000, 1'b0));
    tbl.push_back(mk(5'h12, K_DISP, 16'hED51, 1'b1));
    tbl.push_back(mk(5'h13, K_OP,   16'hED51, 1'b0));
    tbl.push_back(mk(5'h00, K_NONE, 16'h0000, 1'b0));
    tbl.push_back(mk(5'h04, K_DISP, 16'h0004, 1'b0));
    tbl.push_back(mk(5'h05, K_DISP, 16'h0045, 1'b0));
    tbl.push_back(mk(5'h11, K_DISP, 16'h0004, 1'b0));
    tbl.push_back(mk(5'h11, K_DISP, 16'h0000, 1'b0));
    tbl.push_back(mk(5'h11, K_NONE, 16'h0000, 1'b0));
    tbl.push_back(mk(5'h12, K_NONE, 16'h0000, 1'b0));
    tbl.push_back(mk(5'h03, K_DISP, 16'h0003, 1'b0));
    tbl.push_back(mk(5'h12, K_DISP, 16'hFFFD, 1'b1));
    tbl.push_back(mk(5'h11, K_DISP, 16'h0000, 1'b0));
    tbl.push_back(mk(5'h08, K_DISP, 16'h0008, 1'b0));
    tbl.push_back(mk(5'h00, K_DISP, 16'h0080, 1'b0));
    tbl.push_back(mk(5'h00, K_DISP, 16'h0800, 1'b0));
    tbl.push_back(mk(5'h00, K_DISP, 16'h8000, 1'b0));
    tbl.push_back(mk(5'h12, K_DISP, 16'h8000, 1'b1));
    tbl.push_back(mk(5'h1F, K_NONE, 16'h0000, 1'b0));
    tbl.push_back(mk(5'h10, K_DISP, 16'h0000, 1'b0));
    tbl.push_back(mk(5'h10, K_DISP, 16'h0000, 1'b0));

    // Reset state and display initialisation
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready",  32'(o_key_ready),  32'd0);
    chk("rst_disp_valid", 32'(o_disp_valid), 32'd0);
    chk("rst_op_valid",   32'(o_op_valid),   32'd0);
    chk("rst_disp_data",  32'(o_disp_data),  32'd0);
    chk("rst_op_data",    32'(o_op_data),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_no_beat", 32'(o_disp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("init_disp_valid", 32'(o_disp_valid), 32'd1);
    chk("init_disp_data",  32'(o_disp_data),  32'd0);
    chk("init_disp_neg",   32'(o_disp_2s_comp), 32'd0);
    @(posedge clk);
    #1;
    chk("init_idle", 32'(o_key_ready), 32'd1);

    // Table-driven key vectors
    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      press(tbl[i].key);
      case (tbl[i].kind)
        K_DISP: begin
          chk({nm, "_disp_valid"}, 32'(o_disp_valid),   32'd1);
          chk({nm, "_disp_data"},  32'(o_disp_data),    32'(tbl[i].data));
          chk({nm, "_disp_neg"},   32'(o_disp_2s_comp), 32'(tbl[i].neg));
        end
        K_OP: begin
          chk({nm, "_op_valid"}, 32'(o_op_valid), 32'd1);
          chk({nm, "_op_data"},  32'(o_op_data),  32'(tbl[i].data));
        end
        default: begin
          chk({nm, "_no_disp"},  32'(o_disp_valid), 32'd0);
          chk({nm, "_no_op"},    32'(o_op_valid),   32'd0);
          chk({nm, "_ready"},    32'(o_key_ready),  32'd1);
        end
      endcase
    end

    // Operand held under consumer backpressure, then cleared display
    press(5'h03);
    press(5'h12);
    chk("seq1_neg_data", 32'(o_disp_data),    32'h0000FFFD);
    chk("seq1_neg_flag", 32'(o_disp_2s_comp), 32'd1);
    i_op_ready = 1'b0;
    press(5'h13);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("seq1_op_valid_c%0d", c), 32'(o_op_valid), 32'd1);
      chk($sformatf("seq1_op_data_c%0d", c),  32'(o_op_data),  32'h0000FFFD);
    end
    i_op_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("seq1_op_done",    32'(o_op_valid),     32'd0);
    chk("seq1_zero_valid", 32'(o_disp_valid),   32'd1);
    chk("seq1_zero_data",  32'(o_disp_data),    32'd0);
    chk("seq1_zero_neg",   32'(o_disp_2s_comp), 32'd0);

    // Display backpressure with a second key held waiting
    press(5'h10);
    wait_ready("seq2");
    i_disp_ready = 1'b0;
    i_key        = 5'h08;
    i_key_valid  = 1'b1;
    @(posedge clk);
    #1;
    i_key = 5'h09;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("seq2_key_ready_c%0d", c), 32'(o_key_ready),  32'd0);
      chk($sformatf("seq2_disp_data_c%0d", c), 32'(o_disp_data),  32'h00000008);
      chk($sformatf("seq2_disp_vld_c%0d", c),  32'(o_disp_valid), 32'd1);
    end
    i_disp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("seq2_idle", 32'(o_key_ready), 32'd1);
    @(posedge clk);
    #1;
    i_key_valid = 1'b0;
    chk("seq2_disp_valid", 32'(o_disp_valid), 32'd1);
    chk("seq2_disp_data",  32'(o_disp_data),  32'h00000089);

    // Reset while an operand is outstanding
    press(5'h05);
    i_op_ready = 1'b0;
    press(5'h13);
    chk("seq3_in_send", 32'(o_op_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("seq3_op_dropped", 32'(o_op_valid),   32'd0);
    chk("seq3_op_data",    32'(o_op_data),    32'd0);
    chk("seq3_no_disp",    32'(o_disp_valid), 32'd0);
    i_op_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("seq3_disp_valid", 32'(o_disp_valid), 32'd1);
    chk("seq3_disp_data",  32'(o_disp_data),  32'd0);
    chk("seq3_no_op",      32'(o_op_valid),   32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("seq3_never_sent", 32'(o_op_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
